uart_matrix_loader: RTL and testbench

//  Sits directly downstream of uart_rx. Parses the received byte stream into one framed

---
 rtl/uart_matrix_loader.sv | 170 +++++++++++++++++
 tb/tb_uart_matrix_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_matrix_loader
//  Purpose  : Parses a framed UART byte stream into two NxN operand matrices,
//             validating the frame with an XOR checksum and an idle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_matrix_loader #(
    parameter int          N              = 4,
    parameter int          ADDR_W         = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy,
    output logic              mat_valid
);

    localparam int                  c_TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [ADDR_W-1:0]   c_LAST_ELEM = ADDR_W'(N * N - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_MAX   = {c_TMO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic                rx_ready_q,   rx_ready_d;
    logic [ADDR_W-1:0]   cnt_q,        cnt_d;
    logic [7:0]          csum_q,       csum_d;
    logic [c_TMO_W-1:0]  tmo_q,        tmo_d;
    logic                wr_en_q,      wr_en_d;
    logic                wr_sel_q,     wr_sel_d;
    logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
    logic [7:0]          wr_data_q,    wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q,  frame_err_d;
    logic                mat_valid_q,  mat_valid_d;

    logic                w_accept;
    logic                w_busy;

    // Rising edge of the ready level only; a held-high ready is one byte.
    assign w_accept = rx_ready & ~rx_ready_q;
    assign w_busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        rx_ready_d   = rx_ready;
        cnt_d        = cnt_q;
        csum_d       = csum_q;
        tmo_d        = tmo_q;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        mat_valid_d  = mat_valid_q;

        if (w_accept) begin
            tmo_d = '0;
        end else if (w_busy) begin
            if (tmo_q != c_TMO_MAX) begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept && (rx_data == SYNC_BYTE)) begin
                    state_d     = ST_LOAD_A;
                    cnt_d       = '0;
                    csum_d      = 8'h00;
                    mat_valid_d = 1'b0;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                if (w_accept) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == ST_LOAD_B);
                    wr_addr_d = cnt_q;
                    wr_data_d = rx_data;
                    csum_d    = csum_q ^ rx_data;
                    if (cnt_q == c_LAST_ELEM) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    state_d = ST_IDLE;
                    if (rx_data == csum_q) begin
                        frame_done_d = 1'b1;
                        mat_valid_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accept on the same edge as the expiry keeps the frame alive.
        if (w_busy && !w_accept && (tmo_q == c_TMO_LAST)) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            cnt_q        <= '0;
            csum_q       <= 8'h00;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            mat_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            mat_valid_q  <= mat_valid_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = w_busy;
    assign mat_valid  = mat_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_matrix_loader
//  Purpose  : Self-checking bench: frame table plus hand-written corner cases,
//             element writes checked against a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_matrix_loader;

    localparam int         c_N      = 2;
    localparam int         c_ADDR_W = 2;
    localparam logic [7:0] c_SYNC   = 8'hA5;
    localparam int         c_TMO    = 64;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              wr_en;
    logic              wr_sel;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              frame_err;
    logic              busy;
    logic              mat_valid;

    uart_matrix_loader #(
        .N              (c_N),
        .ADDR_W         (c_ADDR_W),
        .SYNC_BYTE      (c_SYNC),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .mat_valid  (mat_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              sel;
        logic [c_ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct {
        logic [7:0] b [10];
        int         exp_done;
        int         exp_err;
        logic       exp_mv;
    } vec_t;

    wr_t  exp_q [$];
    vec_t vecs [4];
    int   n_cmp;
    int   n_fail;
    int   done_cnt;
    int   err_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {wr_sel, 5'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_sel",  {31'd0, wr_sel}, {31'd0, e.sel});
                    chk("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
                    chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_wr(input int idx, input logic [7:0] b);
        wr_t w;
        w.sel  = (idx >= c_N * c_N);
        w.addr = c_ADDR_W'(idx % (c_N * c_N));
        w.data = b;
        exp_q.push_back(w);
    endtask

    // Sends bytes first..9 of a frame; payload positions 1..8 produce writes.
    task automatic send_frame(input vec_t v, input int first);
        for (int i = first; i < 10; i++) begin
            if (i >= 1 && i <= 2 * c_N * c_N) push_wr(i - 1, v.b[i]);
            send_byte(v.b[i]);
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        repeat (3) @(negedge clk);
        chk({tag, "_done"},  done_cnt, v.exp_done);
        chk({tag, "_err"},   err_cnt,  v.exp_err);
        chk({tag, "_mv"},    {31'd0, mat_valid}, {31'd0, v.exp_mv});
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_q"},     exp_q.size(), 0);
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_cmp = 0; n_fail = 0; done_cnt = 0; err_cnt = 0;
        reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;

        vecs[0].b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        vecs[0].exp_done = 1; vecs[0].exp_err = 0; vecs[0].exp_mv = 1'b1;
        vecs[1].b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        vecs[1].exp_done = 0; vecs[1].exp_err = 1; vecs[1].exp_mv = 1'b0;
        vecs[2].b = '{8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hA5};
        vecs[2].exp_done = 1; vecs[2].exp_err = 0; vecs[2].exp_mv = 1'b1;
        vecs[3].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].exp_done = 1; vecs[3].exp_err = 0; vecs[3].exp_mv = 1'b1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_en",  {31'd0, wr_en}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_mv",     {31'd0, mat_valid}, 32'd0);
        chk("rst_done",   {30'd0, frame_done, frame_err}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v], 0);
            check_frame($sformatf("vec%0d", v), vecs[v]);
        end

        // Stray byte ignored, then a frame that stalls and times out.
        push_wr(0, 8'h01);
        push_wr(1, 8'h02);
        send_byte(8'h33);
        send_byte(c_SYNC);
        send_byte(8'h01);
        @(negedge clk);
        rx_data = 8'h02;
        rx_ready = 1'b1;
        @(posedge clk);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) rx_ready = 1'b0;
            if (frame_err) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency", k, c_TMO);
        @(negedge clk);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        chk("tmo_mv",   {31'd0, mat_valid}, 32'd0);
        chk("tmo_q",    exp_q.size(), 0);
        chk("tmo_err",  err_cnt, 1);
        chk("tmo_done", done_cnt, 0);
        done_cnt = 0; err_cnt = 0; exp_q.delete();

        // Ready held high: a single accept, no element written.
        @(negedge clk);
        rx_data = c_SYNC;
        rx_ready = 1'b1;
        repeat (40) @(negedge clk);
        rx_ready = 1'b0;
        chk("hold_busy", {31'd0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        chk("hold_err",  err_cnt, 1);
        chk("hold_idle", {31'd0, busy}, 32'd0);
        done_cnt = 0; err_cnt = 0;

        // Mid-frame reset, then a normal frame.
        push_wr(0, 8'h01);
        send_byte(c_SYNC);
        send_byte(8'h01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_outs", {busy, mat_valid, wr_en, wr_sel, frame_done, frame_err, wr_addr, wr_data}, 32'd0);
        chk("mrst_q", exp_q.size(), 0);
        send_frame(vecs[0], 0);
        check_frame("mrst_frame", vecs[0]);

        // mat_valid falls on the next SYNC accept; A5 payload stays data.
        send_frame(vecs[0], 0);
        check_frame("mv_pre", vecs[0]);
        @(negedge clk);
        rx_data = c_SYNC;
        rx_ready = 1'b1;
        chk("mv_before_accept", {31'd0, mat_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("mv_after_accept", {31'd0, mat_valid}, 32'd0);
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(vecs[2], 1);
        check_frame("mv_frame", vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
